axis_red_pitaya_adc_avg: RTL and testbench
==========================================

Name: axis_red_pitaya_adc_avg

Overview:
Parametrised dual-channel ADC front end: converts raw Red Pitaya ADC words, optionally averages 2^k samples per channel (boxcar decimation), and emits one 32-bit AXI4-Stream beat per averaged pair. Unlike the free-running ADC block, it honours m_axis_tready with a one-beat output register and counts dropped results. It sits between the ADC pins and downstream DMA/FIFO cores.

Parameters:
ADC_DATA_WIDTH, 14, raw ADC word width per channel; legal range 8..16.
LOG2_MAX_DEC, 8, maximum decimation exponent; the largest decimation ratio is 2^LOG2_MAX_DEC.
CNT_WIDTH, 16, width of the dropped-beat status counter.

Ports:
aclk  in  1  system clock; all logic on its rising edge.
areset  in  1  synchronous active-high reset.
adc_dat_a  in  ADC_DATA_WIDTH  raw channel A sample, new sample every cycle.
adc_dat_b  in  ADC_DATA_WIDTH  raw channel B sample.
cfg_enable  in  1  1 = acquire; 0 = hold accumulators cleared.
cfg_invert  in  2  bit0 = channel A, bit1 = channel B; 1 = invert the non-sign bits (Red Pitaya ADC format), 0 = raw two's complement.
cfg_log2_dec  in  4  decimation exponent k; the ratio is 2^k.
m_axis_tready  in  1  downstream ready.
m_axis_tvalid  out  1  output beat valid.
m_axis_tdata  out  32  [15:0] = channel A lane, [31:16] = channel B lane.
sts_drop_cnt  out  CNT_WIDTH  number of averaged results lost to backpressure.

Behaviour:
- Reset (areset=1 at an edge): m_axis_tvalid=0, m_axis_tdata=0, sts_drop_cnt=0; accumulators, sample counter and stage-1 registers cleared; k register loaded from cfg_log2_dec (clamped).
- Stage 1 (registered conversion):
  - With invert=1, s = {d[W-1], ~d[W-2:0]}. With invert=0, s = d.
  - s is a signed W-bit value.
- Effective exponent: k_eff = min(cfg_log2_dec, LOG2_MAX_DEC). It is latched only when the sample counter is 0 (frame start), so a mid-frame change takes effect at the next frame.
- Accumulator: signed, ADC_DATA_WIDTH+LOG2_MAX_DEC bits per channel, so it cannot overflow.
  - Counter cnt runs 0..2^k_eff-1.
  - At cnt=0 the accumulator loads s; otherwise acc += s.
- Result: at cnt = 2^k_eff-1, result = (acc + s) >>> k_eff (arithmetic shift, floor), then sign-extended to 16 bits per lane.
  - cnt wraps to 0.
  - Result becomes available in stage 2 on the next edge.
- Latency: a sample pair at adc_dat_* before edge N appears on m_axis_tdata after edge N+2 when k=0. For k>0, the output follows the last sample of the group by the same 2 edges.
- Output register / handshake:
  - A beat completes on tvalid & tready.
  - When a result arrives, it is loaded and tvalid is set if the register is empty or completes a beat in the same cycle.
  - Otherwise the new result is dropped: tdata and tvalid are held, and sts_drop_cnt increments, saturating at all-ones.
  - tvalid clears on a completed beat with no new result that cycle.
  - tdata never changes while tvalid=1 and tready=0.
- cfg_enable=0: cnt and accumulators are forced to 0 and no new results are produced. A pending beat stays valid until accepted. On re-enable, the first frame starts at cnt=0.
- Reset mid-frame: partial sums are discarded and any pending beat is lost without being counted as a drop.

Test Plan:
- Conversion, k=0, invert=2'b11: a=14'h0000, b=14'h3FFF held, tready=1 -> after 2 edges, tdata=32'hE000_1FFF with tvalid=1 every cycle.
- Raw mode, k=0, invert=0: a=14'h2000, b=14'h0005 -> tdata=32'h0005_E000.
- Averaging, k=2, invert=0, tready=1:
  - a=0,1,2,3 gives lane A=16'h0001 (6>>>2).
  - b=-1,-2,-3,-4 gives lane B=16'hFFFD (floor of -10/4).
  - tvalid pulses once per 4 samples.
- Backpressure, k=0, tready=0 for 10 cycles:
  - tvalid stays 1 and tdata holds the first result.
  - sts_drop_cnt=9 when tready rises.
  - The next accepted beat is the current result, with no stale duplicate.
- Simultaneous events: tready=1 on the cycle a new result arrives with tvalid=1 -> the old beat is accepted, the new result loads, and no drop is counted.
- Mid-frame changes, k=3:
  - cfg_log2_dec changed to 1 at cnt=5: the current frame completes as 8 samples, then pairs follow.
  - areset asserted at cnt=4: outputs are 0 next edge, and the following frame averages 8 fresh samples.
  - cfg_log2_dec=15 behaves as LOG2_MAX_DEC.

Source files
------------

// File: rtl/axis_red_pitaya_adc_avg.sv
// Dual-channel Red Pitaya ADC front end with 2^k boxcar averaging and an
// AXI4-Stream output register that honours tready and counts dropped results.
module axis_red_pitaya_adc_avg #(
  parameter int unsigned ADC_DATA_WIDTH = 14,
  parameter int unsigned LOG2_MAX_DEC   = 8,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [ADC_DATA_WIDTH-1:0] adc_dat_a,
  input  logic [ADC_DATA_WIDTH-1:0] adc_dat_b,
  input  logic                      cfg_enable,
  input  logic [1:0]                cfg_invert,
  input  logic [3:0]                cfg_log2_dec,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tvalid,
  output logic [31:0]               m_axis_tdata,
  output logic [CNT_WIDTH-1:0]      sts_drop_cnt
);

  localparam int unsigned W  = ADC_DATA_WIDTH;
  localparam int unsigned AW = ADC_DATA_WIDTH + LOG2_MAX_DEC;
  localparam int unsigned CW = LOG2_MAX_DEC;

  // Red Pitaya format keeps the sign bit and inverts the magnitude bits
  function automatic logic [W-1:0] conv(input logic [W-1:0] d, input logic inv);
    return inv ? {d[W-1], ~d[W-2:0]} : d;
  endfunction

  logic signed [W-1:0]  s_a, s_b;
  logic                 s_vld;
  logic signed [AW-1:0] acc_a, acc_b;
  logic [CW-1:0]        cnt;
  logic [3:0]           k_reg;
  logic [15:0]          res_a, res_b;
  logic                 res_vld;

  logic [3:0]           k_cfg_c, k_cur_c;
  logic                 last_c;
  logic signed [AW-1:0] ext_a_c, ext_b_c, sum_a_c, sum_b_c;
  logic [15:0]          lane_a_c, lane_b_c;

  // Exponent is only re-read at frame start so a frame always completes at its own ratio
  always_comb begin
    k_cfg_c  = cfg_log2_dec;
    if (32'(cfg_log2_dec) > LOG2_MAX_DEC) k_cfg_c = 4'(LOG2_MAX_DEC);
    k_cur_c  = (cnt == '0) ? k_cfg_c : k_reg;
    last_c   = (32'(cnt) == ((32'd1 << k_cur_c) - 32'd1));
    ext_a_c  = {{LOG2_MAX_DEC{s_a[W-1]}}, s_a};
    ext_b_c  = {{LOG2_MAX_DEC{s_b[W-1]}}, s_b};
    sum_a_c  = (cnt == '0) ? ext_a_c : acc_a + ext_a_c;
    sum_b_c  = (cnt == '0) ? ext_b_c : acc_b + ext_b_c;
    lane_a_c = 16'(sum_a_c >>> k_cur_c);
    lane_b_c = 16'(sum_b_c >>> k_cur_c);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      s_a           <= '0;
      s_b           <= '0;
      s_vld         <= 1'b0;
      acc_a         <= '0;
      acc_b         <= '0;
      cnt           <= '0;
      k_reg         <= k_cfg_c;
      res_a         <= '0;
      res_b         <= '0;
      res_vld       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      sts_drop_cnt  <= '0;
    end else begin
      s_a     <= conv(adc_dat_a, cfg_invert[0]);
      s_b     <= conv(adc_dat_b, cfg_invert[1]);
      s_vld   <= 1'b1;
      k_reg   <= k_cur_c;
      res_vld <= 1'b0;

      // Stage-1 contents after reset are not samples, hence the s_vld gate
      if (!cfg_enable || !s_vld) begin
        cnt   <= '0;
        acc_a <= '0;
        acc_b <= '0;
      end else if (last_c) begin
        cnt     <= '0;
        acc_a   <= '0;
        acc_b   <= '0;
        res_a   <= lane_a_c;
        res_b   <= lane_b_c;
        res_vld <= 1'b1;
      end else begin
        cnt   <= cnt + CW'(1);
        acc_a <= sum_a_c;
        acc_b <= sum_b_c;
      end

      // One-beat output register: a held beat is never overwritten
      if (res_vld) begin
        if (!m_axis_tvalid || m_axis_tready) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= {res_b, res_a};
        end else if (sts_drop_cnt != '1) begin
          sts_drop_cnt <= sts_drop_cnt + CNT_WIDTH'(1);
        end
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_red_pitaya_adc_avg.sv
// Directed bench for axis_red_pitaya_adc_avg: conversion, averaging,
// backpressure, mid-frame exponent change, mid-frame reset and exponent clamp.
module tb_axis_red_pitaya_adc_avg;

  logic        aclk = 1'b0;
  logic        areset;
  logic [13:0] adc_dat_a, adc_dat_b;
  logic        cfg_enable;
  logic [1:0]  cfg_invert;
  logic [3:0]  cfg_log2_dec;
  logic        m_axis_tready;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic [15:0] sts_drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] beats[$];

  always #5 aclk = ~aclk;

  axis_red_pitaya_adc_avg #(
    .ADC_DATA_WIDTH(14),
    .LOG2_MAX_DEC  (8),
    .CNT_WIDTH     (16)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .adc_dat_a    (adc_dat_a),
    .adc_dat_b    (adc_dat_b),
    .cfg_enable   (cfg_enable),
    .cfg_invert   (cfg_invert),
    .cfg_log2_dec (cfg_log2_dec),
    .m_axis_tready(m_axis_tready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata (m_axis_tdata),
    .sts_drop_cnt (sts_drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: record the beat accepted at the coming edge, then drive inputs
  task automatic cycle(input int a, input int b, input logic en, input logic [3:0] k);
    @(negedge aclk);
    if (m_axis_tvalid && m_axis_tready) beats.push_back(m_axis_tdata);
    adc_dat_a    = 14'(a);
    adc_dat_b    = 14'(b);
    cfg_enable   = en;
    cfg_log2_dec = k;
  endtask

  function automatic logic [31:0] beat_at(input int i);
    return (beats.size() > i) ? beats[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic got;

    areset        = 1'b1;
    adc_dat_a     = 14'h0000;
    adc_dat_b     = 14'h3FFF;
    cfg_enable    = 1'b1;
    cfg_invert    = 2'b11;
    cfg_log2_dec  = 4'd0;
    m_axis_tready = 1'b1;
    repeat (2) @(negedge aclk);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tdata", m_axis_tdata, 32'd0);
    check("rst_drop", 32'(sts_drop_cnt), 32'd0);
    areset = 1'b0;

    // Inverted conversion, k=0: valid every cycle
    repeat (5) @(negedge aclk);
    for (int i = 0; i < 3; i++) begin
      check("conv_tdata", m_axis_tdata, 32'hE000_1FFF);
      check("conv_tvalid", 32'(m_axis_tvalid), 32'd1);
      @(negedge aclk);
    end

    // Raw two's complement
    cfg_invert = 2'b00;
    adc_dat_a  = 14'h2000;
    adc_dat_b  = 14'h0005;
    repeat (4) @(negedge aclk);
    check("raw_tdata", m_axis_tdata, 32'h0005_E000);

    // Averaging k=2
    repeat (4) cycle(0, 0, 1'b0, 4'd2);
    beats.delete();
    cycle(0, -1, 1'b0, 4'd2);
    cycle(1, -2, 1'b1, 4'd2);
    cycle(2, -3, 1'b1, 4'd2);
    cycle(3, -4, 1'b1, 4'd2);
    for (int i = 4; i < 8; i++) cycle(i, i, 1'b1, 4'd2);
    cycle(0, 0, 1'b1, 4'd2);
    repeat (6) cycle(0, 0, 1'b0, 4'd2);
    check("avg_nbeats", 32'(beats.size()), 32'd2);
    check("avg_beat0", beat_at(0), 32'hFFFD_0001);
    check("avg_beat1", beat_at(1), 32'h0005_0005);

    // Backpressure, k=0
    repeat (4) cycle(100, 7, 1'b0, 4'd0);
    m_axis_tready = 1'b0;
    cycle(100, 7, 1'b1, 4'd0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge aclk);
      if (m_axis_tvalid) got = 1'b1;
    end
    check("bp_valid_seen", 32'(got), 32'd1);
    check("bp_first", m_axis_tdata, 32'h0007_0064);
    check("bp_drop0", 32'(sts_drop_cnt), 32'd0);
    adc_dat_a = 14'd200;
    repeat (9) @(negedge aclk);
    check("bp_hold_valid", 32'(m_axis_tvalid), 32'd1);
    check("bp_hold_data", m_axis_tdata, 32'h0007_0064);
    check("bp_drop9", 32'(sts_drop_cnt), 32'd9);
    m_axis_tready = 1'b1;
    @(negedge aclk);
    check("bp_next_valid", 32'(m_axis_tvalid), 32'd1);
    check("bp_next_data", m_axis_tdata, 32'h0007_00C8);
    check("bp_simul_nodrop", 32'(sts_drop_cnt), 32'd9);

    // Exponent 3 -> 1 at cnt=5: frame of 8 completes, then pairs
    repeat (4) cycle(0, 0, 1'b0, 4'd3);
    beats.delete();
    cycle(1, -3, 1'b0, 4'd3);
    for (int i = 2; i <= 8; i++) cycle(i, -3, 1'b1, (i >= 7) ? 4'd1 : 4'd3);
    cycle(10, -1, 1'b1, 4'd1);
    cycle(11, -2, 1'b1, 4'd1);
    cycle(20, 0, 1'b1, 4'd1);
    cycle(21, 1, 1'b1, 4'd1);
    cycle(0, 0, 1'b1, 4'd1);
    repeat (6) cycle(0, 0, 1'b0, 4'd1);
    check("midk_nbeats", 32'(beats.size()), 32'd3);
    check("midk_beat0", beat_at(0), 32'hFFFD_0004);
    check("midk_beat1", beat_at(1), 32'hFFFE_000A);
    check("midk_beat2", beat_at(2), 32'h0000_0014);

    // Reset at cnt=4 discards the partial frame
    repeat (4) cycle(100, 100, 1'b0, 4'd3);
    beats.delete();
    repeat (5) cycle(100, 100, 1'b1, 4'd3);
    areset = 1'b1;
    cycle(8, -8, 1'b1, 4'd3);
    areset = 1'b0;
    check("mrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("mrst_tdata", m_axis_tdata, 32'd0);
    check("mrst_drop", 32'(sts_drop_cnt), 32'd0);
    repeat (7) cycle(8, -8, 1'b1, 4'd3);
    cycle(0, 0, 1'b1, 4'd3);
    repeat (5) cycle(0, 0, 1'b0, 4'd3);
    check("mrst_nbeats", 32'(beats.size()), 32'd1);
    check("mrst_beat0", beat_at(0), 32'hFFF8_0008);

    // Exponent 15 clamps to 8: one result per 256 samples
    repeat (4) cycle(0, 0, 1'b0, 4'd15);
    beats.delete();
    for (int i = 0; i < 256; i++) cycle((i < 128) ? 3 : 4, -5, (i != 0), 4'd15);
    cycle(0, 0, 1'b1, 4'd15);
    repeat (6) cycle(0, 0, 1'b0, 4'd15);
    check("clamp_nbeats", 32'(beats.size()), 32'd1);
    check("clamp_beat0", beat_at(0), 32'hFFFB_0003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
